// File: rtl/dadda_mul_arbiter.sv
// Round-robin front end that shares one pipelined 16x16 multiplier among
// NREQ requesters, tagging each issued pair so its product returns to its owner.
module dadda_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [15:0]          mul_mpd,
  output logic [15:0]          mul_mpr,
  input  logic [32:0]          mul_op,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [32:0]          rsp_data,
  output logic                 busy
);

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_next;
  logic [IDW-1:0]  grant_id;
  logic [NREQ-1:0] high_mask;
  logic [NREQ-1:0] masked_valid;
  logic [NREQ-1:0] pick_valid;
  logic [NREQ-1:0] grant;
  logic [15:0]     sel_a;
  logic [15:0]     sel_b;
  logic [15:0]     slice_a [0:NREQ-1];
  logic [15:0]     slice_b [0:NREQ-1];
  logic            xfer;

  logic [MUL_LAT:0] tag_valid;
  logic [IDW-1:0]   tag_id [0:MUL_LAT];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign slice_a[gi] = req_a[16*gi +: 16];
      assign slice_b[gi] = req_b[16*gi +: 16];
    end
  endgenerate

  // Requesters at or above ptr win first; if none is valid, wrap to the lowest index.
  assign high_mask    = ~((NREQ'(1) << ptr) - NREQ'(1));
  assign masked_valid = req_valid & high_mask;
  assign pick_valid   = (|masked_valid) ? masked_valid : req_valid;
  assign grant        = en ? (pick_valid & (~pick_valid + NREQ'(1))) : '0;
  assign req_ready    = grant;
  assign xfer         = |grant;

  always_comb begin
    grant_id = '0;
    ptr_next = ptr;
    sel_a    = '0;
    sel_b    = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant[j]) begin
        grant_id = IDW'(j);
        ptr_next = (j == NREQ - 1) ? '0 : IDW'(j + 1);
        sel_a    = slice_a[j];
        sel_b    = slice_b[j];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      mul_mpd   <= '0;
      mul_mpr   <= '0;
      tag_valid <= '0;
      for (int k = 0; k <= MUL_LAT; k++) begin
        tag_id[k] <= '0;
      end
    end else begin
      if (xfer) begin
        ptr     <= ptr_next;
        mul_mpd <= sel_a;
        mul_mpr <= sel_b;
      end
      tag_valid[0] <= xfer;
      tag_id[0]    <= grant_id;
      // Tag stage k lines up with the operands issued k cycles ago.
      for (int k = 1; k <= MUL_LAT; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_id[k]    <= tag_id[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= tag_valid[MUL_LAT];
      if (tag_valid[MUL_LAT]) begin
        rsp_id   <= tag_id[MUL_LAT];
        rsp_data <= mul_op;
      end
      // Next-cycle view of the tag pipe plus response register.
      busy <= xfer | (|tag_valid);
    end
  end

endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// Bench for dadda_mul_arbiter: a pipelined multiplier model feeds mul_op, and a
// scoreboard matches every accepted pair against its response, id and arrival cycle.
module tb_dadda_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int MUL_LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [NREQ-1:0]   req_valid;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [15:0]       mul_mpd;
  logic [15:0]       mul_mpr;
  logic [32:0]       mul_op;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [32:0]       rsp_data;
  logic              busy;

  typedef struct {
    int          id;
    logic [32:0] data;
    longint      due;
  } sb_t;

  sb_t    sb[$];
  sb_t    mon_e;
  int     vectors = 0;
  int     miscompares = 0;
  longint cyc = 0;
  logic [32:0] m0, m1;

  dadda_mul_arbiter #(.NREQ(NREQ), .IDW(IDW), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_mpd(mul_mpd), .mul_mpr(mul_mpr), .mul_op(mul_op),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Two-stage multiplier standing in for dadda_16_16.
  always @(posedge clk) begin
    m0 <= 33'(mul_mpd) * 33'(mul_mpr);
    m1 <= m0;
  end
  assign mul_op = m1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (rsp_valid) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_rsp id=%0d data=%0d cyc=%0d", rsp_id, rsp_data, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (int'(rsp_id) !== mon_e.id || rsp_data !== mon_e.data || cyc !== mon_e.due) begin
            miscompares++;
            $display("FAIL rsp got id=%0d data=%0d cyc=%0d want id=%0d data=%0d cyc=%0d",
                     rsp_id, rsp_data, cyc, mon_e.id, mon_e.data, mon_e.due);
          end
        end
      end
      for (int j = 0; j < NREQ; j++) begin
        if (req_valid[j] && req_ready[j]) begin
          sb.push_back('{j, 33'(req_a[16*j +: 16]) * 33'(req_b[16*j +: 16]),
                         cyc + MUL_LAT + 2});
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout got pending=%0d want 0", sb.size());
    end
    repeat (2) next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({req_ready, mul_mpd, mul_mpr, rsp_valid, rsp_id, rsp_data, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got ready=%b mpd=%0d mpr=%0d rv=%b id=%0d data=%0d busy=%b want all 0",
               req_ready, mul_mpd, mul_mpr, rsp_valid, rsp_id, rsp_data, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      vectors++;
      if (req_ready !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL idle[%0d] got ready=%b rv=%b busy=%b want 0 0 0", k, req_ready, rsp_valid, busy);
      end
      next_cycle();
    end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] want;
    for (int i = 0; i < NREQ; i++) begin
      req_a[16*i +: 16] = 16'(i + 1);
      req_b[16*i +: 16] = 16'hFFFF;
    end
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      want = NREQ'(1) << (k % NREQ);
      @(negedge clk);
      vectors++;
      if (req_ready !== want) begin
        miscompares++;
        $display("FAIL contention_grant[%0d] got %b want %b", k, req_ready, want);
      end
      next_cycle();
    end
    req_valid = '0;
    wait_drain();
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] want [0:4];
    want[0] = 4'b0010; want[1] = 4'b1000; want[2] = 4'b0010; want[3] = 4'b1000; want[4] = 4'b0001;
    req_a = {16'd41, 16'd31, 16'd21, 16'd11};
    req_b = {16'd42, 16'd32, 16'd22, 16'd12};
    for (int k = 0; k < 5; k++) begin
      req_valid = (k < 4) ? 4'b1010 : 4'b1011;
      @(negedge clk);
      vectors++;
      if (req_ready !== want[k]) begin
        miscompares++;
        $display("FAIL fairness_grant[%0d] got %b want %b", k, req_ready, want[k]);
      end
      next_cycle();
    end
    req_valid = '0;
    wait_drain();
  endtask

  task automatic test_single();
    int          seen_at = -1;
    logic [32:0] seen_data = '0;
    logic [IDW-1:0] seen_id = '0;
    req_a[16*2 +: 16] = 16'd300;
    req_b[16*2 +: 16] = 16'd7;
    req_valid = 4'b0100;
    @(negedge clk);
    vectors++;
    if (req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL single_grant got %b want 0100", req_ready);
    end
    next_cycle();
    req_valid = '0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (rsp_valid && seen_at < 0) begin
        seen_at = n; seen_data = rsp_data; seen_id = rsp_id;
      end
      next_cycle();
    end
    vectors++;
    if (seen_at !== 4 || seen_data !== 33'd2100 || seen_id !== 2'd2) begin
      miscompares++;
      $display("FAIL single_rsp got lat=%0d id=%0d data=%0d want lat=4 id=2 data=2100",
               seen_at, seen_id, seen_data);
    end
    wait_drain();
  endtask

  task automatic test_en_drain();
    logic [15:0] av [0:2];
    logic [15:0] bv [0:2];
    av[0] = 16'd11; av[1] = 16'd17; av[2] = 16'd23;
    bv[0] = 16'd13; bv[1] = 16'd19; bv[2] = 16'd29;
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'b0001;
      req_a[15:0] = av[k];
      req_b[15:0] = bv[k];
      @(negedge clk);
      vectors++;
      if (req_ready !== 4'b0001) begin
        miscompares++;
        $display("FAIL en_issue[%0d] got %b want 0001", k, req_ready);
      end
      next_cycle();
    end
    en = 1'b0;
    req_valid = '1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      vectors++;
      if (req_ready !== '0 || busy !== (k <= 4)) begin
        miscompares++;
        $display("FAIL en_drain[%0d] got ready=%b busy=%b want ready=0000 busy=%b",
                 k, req_ready, busy, (k <= 4));
      end
      next_cycle();
    end
    req_valid = '0;
    en = 1'b1;
    wait_drain();
  endtask

  task automatic test_async_reset();
    req_valid = 4'b0001;
    req_a[15:0] = 16'd1000; req_b[15:0] = 16'd1000;
    @(negedge clk);
    next_cycle();
    req_a[15:0] = 16'd2000; req_b[15:0] = 16'd3;
    @(negedge clk);
    next_cycle();
    req_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({req_ready, mul_mpd, mul_mpr, rsp_valid, rsp_id, rsp_data, busy} !== '0) begin
      miscompares++;
      $display("FAIL async_reset got ready=%b mpd=%0d mpr=%0d rv=%b id=%0d data=%0d busy=%b want all 0",
               req_ready, mul_mpd, mul_mpr, rsp_valid, rsp_id, rsp_data, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset[%0d] got rv=%b busy=%b want 0 0", k, rsp_valid, busy);
      end
      next_cycle();
    end
  endtask

  task automatic test_sweep();
    req_valid = 4'b0001;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        req_a[15:0] = 16'(a);
        req_b[15:0] = 16'(b);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin
          miscompares++;
          $display("FAIL sweep_grant a=%0d b=%0d got %b want 0001", a, b, req_ready);
        end
        next_cycle();
      end
    end
    req_valid = '0;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_fairness();
    test_single();
    test_en_drain();
    test_async_reset();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
